// File: rtl/xf100_ifu_exu_fifo.sv
// rtl/xf100_ifu_exu_fifo.sv - IFU-to-EXU instruction/PC decoupling queue with flush
`ifndef XF100_INSTR_SIZE
`define XF100_INSTR_SIZE 32
`endif
`ifndef XF100_PC_SIZE
`define XF100_PC_SIZE 32
`endif

module xf100_ifu_exu_fifo #(
    parameter int DEPTH_LOG2 = 2
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         flush_i,
    input  logic                         ifu_i_valid,
    output logic                         ifu_i_ready,
    input  logic [`XF100_INSTR_SIZE-1:0] ifu_i_instr,
    input  logic [`XF100_PC_SIZE-1:0]    ifu_i_pc,
    output logic                         exu_o_valid,
    input  logic                         exu_o_ready,
    output logic [`XF100_INSTR_SIZE-1:0] exu_o_instr,
    output logic [`XF100_PC_SIZE-1:0]    exu_o_pc,
    output logic [DEPTH_LOG2:0]          fifo_o_count
);
    localparam int IW    = `XF100_INSTR_SIZE;
    localparam int PW    = `XF100_PC_SIZE;
    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_COUNT = (DEPTH_LOG2+1)'(DEPTH);

    logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
    logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
    logic [DEPTH_LOG2:0]   count_q, count_d;
    logic [IW-1:0]         instr_q [DEPTH];
    logic [IW-1:0]         instr_d [DEPTH];
    logic [PW-1:0]         pc_q    [DEPTH];
    logic [PW-1:0]         pc_d    [DEPTH];
    logic                  push;
    logic                  pop;

    // Ready depends only on registered count and flush, never on exu_o_ready.
    assign ifu_i_ready  = (count_q != FULL_COUNT) & ~flush_i;
    assign exu_o_valid  = (count_q != '0);
    assign exu_o_instr  = instr_q[rptr_q];
    assign exu_o_pc     = pc_q[rptr_q];
    assign fifo_o_count = count_q;
    assign push         = ifu_i_valid & ifu_i_ready;
    assign pop          = exu_o_valid & exu_o_ready;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        instr_d = instr_q;
        pc_d    = pc_q;
        if (flush_i) begin
            wptr_d  = '0;
            rptr_d  = '0;
            count_d = '0;
        end else begin
            if (push) begin
                instr_d[wptr_q] = ifu_i_instr;
                pc_d[wptr_q]    = ifu_i_pc;
                wptr_d          = wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_d = rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_d = count_q + 1'b1;
                2'b01:   count_d = count_q - 1'b1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                instr_q[i] <= '0;
                pc_q[i]    <= '0;
            end
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
            instr_q <= instr_d;
            pc_q    <= pc_d;
        end
    end
endmodule

// File: tb/tb_xf100_ifu_exu_fifo.sv
// tb/tb_xf100_ifu_exu_fifo.sv - scoreboard bench for the IFU/EXU decoupling queue
`timescale 1ns/1ps
`ifndef XF100_INSTR_SIZE
`define XF100_INSTR_SIZE 32
`endif
`ifndef XF100_PC_SIZE
`define XF100_PC_SIZE 32
`endif

module tb_xf100_ifu_exu_fifo;
    localparam int IW = `XF100_INSTR_SIZE;
    localparam int PW = `XF100_PC_SIZE;

    logic          clk = 1'b0;
    logic          rst;
    logic          flush_i;
    logic          ifu_i_valid;
    logic          ifu_i_ready;
    logic [IW-1:0] ifu_i_instr;
    logic [PW-1:0] ifu_i_pc;
    logic          exu_o_valid;
    logic          exu_o_ready;
    logic [IW-1:0] exu_o_instr;
    logic [PW-1:0] exu_o_pc;
    logic [2:0]    fifo_o_count;

    xf100_ifu_exu_fifo #(.DEPTH_LOG2(2)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush_i      (flush_i),
        .ifu_i_valid  (ifu_i_valid),
        .ifu_i_ready  (ifu_i_ready),
        .ifu_i_instr  (ifu_i_instr),
        .ifu_i_pc     (ifu_i_pc),
        .exu_o_valid  (exu_o_valid),
        .exu_o_ready  (exu_o_ready),
        .exu_o_instr  (exu_o_instr),
        .exu_o_pc     (exu_o_pc),
        .fifo_o_count (fifo_o_count)
    );

    always #5 clk = ~clk;

    int            n_assert = 0;
    int            n_fail   = 0;
    int            m_count  = 0;
    logic [IW-1:0] sb_instr [$];
    logic [PW-1:0] sb_pc    [$];
    logic          last_push;

    function automatic logic [IW-1:0] mk_instr(input logic [PW-1:0] pc);
        return IW'(pc) ^ IW'(32'hDEAD_BEEF);
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive at the falling edge, check outputs, then advance the model.
    task automatic cycle(input logic v, input logic [PW-1:0] pc, input logic er, input logic fl);
        logic exp_ready;
        logic do_push;
        logic do_pop;
        @(negedge clk);
        ifu_i_valid = v;
        ifu_i_pc    = pc;
        ifu_i_instr = mk_instr(pc);
        exu_o_ready = er;
        flush_i     = fl;
        #1;
        exp_ready = (m_count != 4) && !fl;
        chk("ifu_i_ready", 64'(ifu_i_ready), 64'(exp_ready));
        chk("exu_o_valid", 64'(exu_o_valid), 64'(m_count != 0));
        chk("fifo_o_count", 64'(fifo_o_count), 64'(m_count));
        if (m_count != 0) begin
            chk("exu_o_instr", 64'(exu_o_instr), 64'(sb_instr[0]));
            chk("exu_o_pc", 64'(exu_o_pc), 64'(sb_pc[0]));
        end
        do_push = 1'b0;
        if (fl) begin
            sb_instr.delete();
            sb_pc.delete();
            m_count = 0;
        end else begin
            do_pop  = (m_count != 0) && er;
            do_push = v && exp_ready;
            if (do_pop) begin
                void'(sb_instr.pop_front());
                void'(sb_pc.pop_front());
                m_count--;
            end
            if (do_push) begin
                sb_instr.push_back(mk_instr(pc));
                sb_pc.push_back(pc);
                m_count++;
            end
        end
        last_push = do_push;
    endtask

    initial begin
        logic [PW-1:0] pc;
        logic          pend_v;
        rst         = 1'b1;
        flush_i     = 1'b0;
        ifu_i_valid = 1'b0;
        ifu_i_instr = '0;
        ifu_i_pc    = '0;
        exu_o_ready = 1'b0;

        // Reset state
        @(negedge clk);
        #1;
        chk("rst_valid", 64'(exu_o_valid), 64'd0);
        chk("rst_count", 64'(fifo_o_count), 64'd0);
        chk("rst_instr", 64'(exu_o_instr), 64'd0);
        chk("rst_pc", 64'(exu_o_pc), 64'd0);
        chk("rst_ready", 64'(ifu_i_ready), 64'd1);
        rst = 1'b0;

        // Fill and drain, including a rejected fifth push
        for (int k = 0; k < 4; k++) cycle(1'b1, PW'(4 * k), 1'b0, 1'b0);
        cycle(1'b1, PW'(32'h10), 1'b0, 1'b0);
        for (int k = 0; k < 4; k++) cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Streaming with both sides ready
        for (int k = 0; k < 20; k++) cycle(1'b1, PW'(32'h100 + 4 * k), 1'b1, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Full with simultaneous push and pop, then flush with concurrent traffic
        for (int k = 0; k < 4; k++) cycle(1'b1, PW'(32'h200 + 4 * k), 1'b0, 1'b0);
        cycle(1'b1, PW'(32'h300), 1'b1, 1'b0);
        cycle(1'b1, PW'(32'h304), 1'b1, 1'b1);
        cycle(1'b1, PW'(32'h308), 1'b0, 1'b0);
        for (int k = 0; k < 2; k++) cycle(1'b0, '0, 1'b1, 1'b0);

        // Asynchronous reset mid-stream
        cycle(1'b1, PW'(32'h400), 1'b0, 1'b0);
        cycle(1'b1, PW'(32'h404), 1'b0, 1'b0);
        @(negedge clk);
        ifu_i_valid = 1'b1;
        ifu_i_pc    = PW'(32'h408);
        ifu_i_instr = mk_instr(PW'(32'h408));
        exu_o_ready = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_valid", 64'(exu_o_valid), 64'd0);
        chk("arst_instr", 64'(exu_o_instr), 64'd0);
        chk("arst_pc", 64'(exu_o_pc), 64'd0);
        chk("arst_count", 64'(fifo_o_count), 64'd0);
        sb_instr.delete();
        sb_pc.delete();
        m_count = 0;
        @(negedge clk);
        #1;
        chk("arst_hold_count", 64'(fifo_o_count), 64'd0);
        ifu_i_valid = 1'b0;
        rst = 1'b0;
        cycle(1'b1, PW'(32'h500), 1'b0, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);
        cycle(1'b0, '0, 1'b1, 1'b0);

        // Random backpressure; an unaccepted offer is held stable
        pc        = PW'(32'h1000);
        pend_v    = 1'b0;
        last_push = 1'b0;
        for (int k = 0; k < 10000; k++) begin
            logic fl;
            if (!pend_v) pend_v = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 99) == 0);
            cycle(pend_v, pc, 1'($urandom_range(0, 1)), fl);
            if (last_push || fl) begin
                if (last_push) pc = pc + 4;
                pend_v = 1'b0;
            end
        end
        for (int k = 0; k < 5; k++) cycle(1'b0, '0, 1'b1, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
